// File: rtl/pmem_arbiter_pkg.sv
// Shared types and default geometry for the icache/dcache to pmem arbiter.
package pmem_arbiter_pkg;
    localparam int ARB_ADDR_WIDTH  = 32;
    localparam int ARB_LINE_WIDTH  = 256;
    localparam int ARB_BURST_WIDTH = 64;
    localparam int ARB_BEATS       = ARB_LINE_WIDTH / ARB_BURST_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        I_READ,
        D_READ,
        D_WRITE,
        DONE
    } arb_state_t;

    typedef enum logic {
        INSTR,
        DATA
    } requester_t;

    function automatic requester_t other_requester(input requester_t r);
        return (r == INSTR) ? DATA : INSTR;
    endfunction
endpackage

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one 64-bit burst pmem port between the icache
// and dcache; runs 4-beat line bursts and pulses a one-cycle completion.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = ARB_ADDR_WIDTH,
    parameter int LINE_WIDTH  = ARB_LINE_WIDTH,
    parameter int BURST_WIDTH = ARB_BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_read,
    input  logic [ADDR_WIDTH-1:0]  i_address,
    output logic [LINE_WIDTH-1:0]  i_rdata,
    output logic                   i_resp,
    input  logic                   d_read,
    input  logic                   d_write,
    input  logic [ADDR_WIDTH-1:0]  d_address,
    input  logic [LINE_WIDTH-1:0]  d_wdata,
    output logic [LINE_WIDTH-1:0]  d_rdata,
    output logic                   d_resp,
    output logic                   pmem_read,
    output logic                   pmem_write,
    output logic [ADDR_WIDTH-1:0]  pmem_address,
    output logic [BURST_WIDTH-1:0] pmem_wdata,
    input  logic [BURST_WIDTH-1:0] pmem_rdata,
    input  logic                   pmem_resp
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    arb_state_t             state;
    arb_state_t             state_next;
    requester_t             last_grant;
    logic [CNT_W-1:0]       cnt;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [LINE_WIDTH-1:0]  wline;
    logic [LINE_WIDTH-1:0]  buffer;
    logic [LINE_WIDTH-1:0]  buffer_merged;
    logic [LINE_WIDTH-1:0]  i_line;
    logic [LINE_WIDTH-1:0]  d_line;

    logic i_req;
    logic d_req;
    logic grant_d;
    logic bursting;
    logic beat;
    logic last_beat;

    always_comb begin
        i_req     = i_read;
        d_req     = d_read | d_write;
        // On a tie the requester not served last wins; after reset that is data.
        grant_d   = d_req && (!i_req || other_requester(last_grant) == DATA);
        bursting  = (state == I_READ) || (state == D_READ) || (state == D_WRITE);
        beat      = bursting && pmem_resp;
        last_beat = beat && (cnt == LAST_BEAT);
    end

    always_comb begin
        buffer_merged = buffer;
        buffer_merged[BURST_WIDTH*cnt +: BURST_WIDTH] = pmem_rdata;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = d_write ? D_WRITE : D_READ;
                end else if (i_req) begin
                    state_next = I_READ;
                end
            end
            I_READ, D_READ, D_WRITE: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= INSTR;
            cnt        <= '0;
            base_addr  <= '0;
            wline      <= '0;
            buffer     <= '0;
            i_line     <= '0;
            d_line     <= '0;
        end else begin
            state <= state_next;

            if (state == IDLE && (i_req || d_req)) begin
                last_grant <= grant_d ? DATA : INSTR;
                base_addr  <= (grant_d ? d_address : i_address) & LINE_MASK;
                if (grant_d && d_write) begin
                    wline <= d_wdata;
                end
            end

            if (beat) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
                if (state != D_WRITE) begin
                    buffer <= buffer_merged;
                end
            end

            // The completed line is published as the last beat lands so it is
            // already visible during the DONE cycle.
            if (last_beat && state == I_READ) begin
                i_line <= buffer_merged;
            end
            if (last_beat && state == D_READ) begin
                d_line <= buffer_merged;
            end
        end
    end

    always_comb begin
        pmem_read    = (state == I_READ) || (state == D_READ);
        pmem_write   = (state == D_WRITE);
        pmem_address = bursting ? base_addr : '0;
        pmem_wdata   = pmem_write ? wline[BURST_WIDTH*cnt +: BURST_WIDTH] : '0;
        i_resp       = (state == DONE) && (last_grant == INSTR);
        d_resp       = (state == DONE) && (last_grant == DATA);
        i_rdata      = i_line;
        d_rdata      = d_line;
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed and randomized bench for pmem_arbiter against a line-level memory
// and round-robin model.
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    pmem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [logic [31:0]];
    int          stall_max   = 0;
    bit          spurious_en = 1'b0;
    int          glitches    = 0;
    int          beats_done  = 0;
    logic [31:0] last_base   = '0;

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
        return mem[a];
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] a);
        return a - (a % 32);
    endfunction

    function automatic logic [255:0] line_at(input logic [31:0] a);
        logic [31:0] b;
        b = line_base(a);
        return {mem_rd(b + 24), mem_rd(b + 16), mem_rd(b + 8), mem_rd(b)};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(output bit gi, output bit gd, output int cyc);
        gi  = 1'b0;
        gd  = 1'b0;
        cyc = 0;
        while (!gi && !gd && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            gi = i_resp;
            gd = d_resp;
        end
    endtask

    task automatic new_d_req();
        d_address = $urandom;
        if ($urandom_range(1, 0) == 1) begin
            d_write = 1'b1;
            d_read  = 1'b0;
            for (int k = 0; k < 8; k++) d_wdata[32*k +: 32] = $urandom;
        end else begin
            d_write = 1'b0;
            d_read  = 1'b1;
        end
    endtask

    // pmem slave: beat k of a burst lives at base + 8*k; optional stalls and
    // stray resp pulses outside bursts.
    initial begin : responder
        int          rbeat;
        int          stall;
        bit          in_burst;
        logic [31:0] b_addr;
        logic        b_rd;
        rbeat = 0; stall = 0; in_burst = 1'b0; b_addr = '0; b_rd = 1'b0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            pmem_resp = 1'b0;
            if (rst) begin
                rbeat = 0; stall = 0; in_burst = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!in_burst) begin
                    in_burst  = 1'b1;
                    b_addr    = pmem_address;
                    b_rd      = pmem_read;
                    last_base = pmem_address;
                    stall     = $urandom_range(stall_max, 0);
                end else if (pmem_address !== b_addr || pmem_read !== b_rd || pmem_write !== !b_rd) begin
                    glitches++;
                end
                if (stall > 0) begin
                    stall--;
                end else begin
                    pmem_resp = 1'b1;
                    if (pmem_read) begin
                        pmem_rdata = mem_rd(pmem_address + 32'(8 * rbeat));
                    end else begin
                        mem[pmem_address + 32'(8 * rbeat)] = pmem_wdata;
                        pmem_rdata = {$urandom, $urandom};
                    end
                    rbeat = (rbeat + 1) % ARB_BEATS;
                    beats_done++;
                    stall = $urandom_range(stall_max, 0);
                end
            end else begin
                in_burst = 1'b0;
                if (spurious_en && $urandom_range(1, 0) == 1) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = {$urandom, $urandom};
                end
            end
        end
    end

    initial begin
        bit           gi, gd, last_was_d, was_write;
        int           cyc, n, start, seen;
        logic [255:0] line1, line2, exp_line;
        logic [31:0]  a;

        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_address", pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        check("rst_i_resp", i_resp, 0);
        check("rst_d_resp", d_resp, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;

        // icache read of 0x1234 with back-to-back beats
        mem[32'h0000_1220] = 64'h1111_1111_1111_1111;
        mem[32'h0000_1228] = 64'h2222_2222_2222_2222;
        mem[32'h0000_1230] = 64'h3333_3333_3333_3333;
        mem[32'h0000_1238] = 64'h4444_4444_4444_4444;
        line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        @(posedge clk);
        #1;
        i_read = 1'b1;
        i_address = 32'h0000_1234;
        wait_resp(gi, gd, cyc);
        check("t1_i_resp", gi, 1);
        check("t1_d_resp", gd, 0);
        check("t1_latency", cyc, 5);
        check("t1_base", last_base, 32'h0000_1220);
        check("t1_rdata", i_rdata, line1);
        i_read = 1'b0;
        @(posedge clk);
        #1;
        check("t1_pulse", i_resp, 0);
        check("t1_hold", i_rdata, line1);
        check("t1_idle_read", pmem_read, 0);

        // dcache writeback to 0x8040
        line2 = {64'hDDDD_DDDD_DDDD_0003, 64'hCCCC_CCCC_CCCC_0002,
                 64'hBBBB_BBBB_BBBB_0001, 64'hAAAA_AAAA_AAAA_0000};
        d_write = 1'b1;
        d_address = 32'h0000_8040;
        d_wdata = line2;
        wait_resp(gi, gd, cyc);
        check("t2_d_resp", gd, 1);
        check("t2_i_resp", gi, 0);
        check("t2_base", last_base, 32'h0000_8040);
        d_write = 1'b0;
        for (int k = 0; k < ARB_BEATS; k++)
            check("t2_wbeat", mem_rd(32'h0000_8040 + 32'(8 * k)), line2[64*k +: 64]);
        check("t2_glitch", glitches, 0);

        // simultaneous requests right after reset: data first, then instr
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        i_read = 1'b1; i_address = $urandom;
        d_read = 1'b1; d_address = $urandom;
        wait_resp(gi, gd, cyc);
        check("t3_first_d", gd, 1);
        check("t3_first_not_i", gi, 0);
        check("t3_d_rdata", d_rdata, line_at(d_address));
        d_read = 1'b0;
        wait_resp(gi, gd, cyc);
        check("t3_second_i", gi, 1);
        check("t3_gap", cyc, 6);
        check("t3_i_rdata", i_rdata, line_at(i_address));

        // both keep requesting under random stalls and stray resp pulses
        stall_max = 3;
        spurious_en = 1'b1;
        last_was_d = 1'b0;
        i_address = $urandom;
        new_d_req();
        for (int t = 0; t < 6; t++) begin
            wait_resp(gi, gd, cyc);
            check("t4_grant_d", gd, !last_was_d);
            check("t4_grant_i", gi, last_was_d);
            if (gd) begin
                was_write = d_write;
                if (was_write) begin
                    for (int k = 0; k < ARB_BEATS; k++)
                        check("t4_wbeat", mem_rd(line_base(d_address) + 32'(8 * k)), d_wdata[64*k +: 64]);
                end else begin
                    check("t4_d_rdata", d_rdata, line_at(d_address));
                end
                new_d_req();
            end
            if (gi) begin
                check("t4_i_rdata", i_rdata, line_at(i_address));
                i_address = $urandom;
            end
            last_was_d = gd;
        end
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        check("t4_glitch", glitches, 0);
        spurious_en = 1'b0;

        // reset after the second beat of a dcache read
        stall_max = 1;
        repeat (3) @(posedge clk);
        #1;
        d_read = 1'b1;
        d_address = $urandom;
        start = beats_done;
        n = 0;
        while (beats_done < start + 2 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_two_beats", beats_done - start, 2);
        rst = 1'b1;
        d_read = 1'b0;
        @(posedge clk);
        #1;
        check("t5_read_drop", pmem_read, 0);
        check("t5_no_resp", d_resp, 0);
        check("t5_rdata_clr", d_rdata, 0);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (d_resp || i_resp || pmem_read) seen++;
        end
        check("t5_quiet", seen, 0);
        a = $urandom;
        exp_line = line_at(a);
        d_read = 1'b1;
        d_address = a;
        wait_resp(gi, gd, cyc);
        check("t5_after_d_resp", gd, 1);
        check("t5_after_rdata", d_rdata, exp_line);
        d_read = 1'b0;
        check("t5_glitch", glitches, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single 64-bit burst physical-memory port between the instruction cache and the data cache.
- Each cache issues 256-bit line requests. The arbiter grants one requester, runs a 4-beat burst on pmem, assembles or disassembles the line, and pulses a response back.
- Sits between the cache layer and pmem inside the cpu top.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cache line width in bits.
- BURST_WIDTH, 64, pmem beat width; BEATS = LINE_WIDTH/BURST_WIDTH = 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_read  in  1  icache line read request
- i_address  in  ADDR_WIDTH  icache line address
- i_rdata  out  LINE_WIDTH  line returned to icache
- i_resp  out  1  icache completion pulse
- d_read  in  1  dcache line read request
- d_write  in  1  dcache line writeback request
- d_address  in  ADDR_WIDTH  dcache line address
- d_wdata  in  LINE_WIDTH  dcache writeback line
- d_rdata  out  LINE_WIDTH  line returned to dcache
- d_resp  out  1  dcache completion pulse
- pmem_read  out  1  pmem burst read
- pmem_write  out  1  pmem burst write
- pmem_address  out  ADDR_WIDTH  burst base address
- pmem_wdata  out  BURST_WIDTH  write beat data
- pmem_rdata  in  BURST_WIDTH  read beat data
- pmem_resp  in  1  one pulse per completed beat

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset effects:
  - state=IDLE, beat counter=0, line buffer=0, last_grant=INSTR.
  - All outputs 0, with i_rdata/d_rdata = 0.
  - Reset mid-burst aborts immediately with no resp pulse; pmem_read/pmem_write drop the next cycle.
- States: IDLE, I_READ, D_READ, D_WRITE, DONE.
- IDLE arbitration, evaluated on registered state each cycle:
  - One requester pending: grant it.
  - Both pending: grant the requester not equal to last_grant (round-robin). After reset this gives data priority on a tie.
  - d_write and d_read both high is illegal; d_write wins.
  - On grant: latch the line address with low log2(LINE_WIDTH/8)=5 bits forced to 0, latch d_wdata for writes, update last_grant, go to the burst state.
- Burst states:
  - pmem_read is high in I_READ/D_READ; pmem_write is high in D_WRITE. Held continuously for all 4 beats.
  - pmem_address holds the latched base address for the whole burst.
  - Write: pmem_wdata = latched_line[BURST_WIDTH*cnt +: BURST_WIDTH].
  - Read: on pmem_resp, buffer[BURST_WIDTH*cnt +: BURST_WIDTH] <= pmem_rdata.
  - On each pmem_resp cnt increments; on the 4th pmem_resp (cnt==3) cnt wraps to 0 and state goes to DONE.
  - pmem_read/pmem_write deassert in DONE.
- DONE: lasts exactly 1 cycle.
  - i_resp or d_resp = 1 for the granted requester.
  - i_rdata/d_rdata present the assembled line, held stable until that requester's next completion.
  - Next state is IDLE.
- Requester protocol:
  - Hold the request and address stable until resp.
  - Deassert the request in the cycle after resp. IDLE samples in that cycle, so a still-high request is a new request.
  - A request dropped mid-burst is a protocol violation; the arbiter still completes the burst and pulses resp.
- Latency, best case (pmem_resp every cycle): request seen in IDLE at cycle 0, pmem_read at cycle 1, beats at cycles 1-4, resp at cycle 5.
- pmem_resp outside a burst state is ignored.

Decomposition:
- Shared package, rv32i_types or an arbiter package:
  - enum arb_state_t {IDLE, I_READ, D_READ, D_WRITE, DONE}
  - enum requester_t {INSTR, DATA}
  - constants LINE_WIDTH, BURST_WIDTH, BEATS
- Single module; no sub-module needed. Optional small line_buffer shift/indexed register is left inline.

Test Plan:
- Icache read only, address 0x0000_1234, pmem_rdata beats 0x11..,0x22..,0x33..,0x44.. -> pmem_address=0x0000_1220, 4 beats, i_resp pulses 1 cycle, i_rdata = {beat3,beat2,beat1,beat0}, d_resp stays 0.
- Dcache writeback of line 0xDDDD...0003_..._0000 to 0x0000_8040 -> pmem_write high for 4 resp beats, pmem_wdata = line[63:0], [127:64], [191:128], [255:192] in order; d_resp pulse after 4th beat.
- i_read and d_read asserted same cycle right after reset -> dcache granted first (last_grant=INSTR). The icache is served in the next IDLE after d_resp, with exactly one IDLE cycle between bursts.
- Both requesters continuously re-requesting for 4 transactions -> grants alternate D,I,D,I; no starvation.
- pmem_resp stalls of 0-3 random cycles between beats -> pmem_address/pmem_read stable throughout, data assembled correctly, resp only after 4th beat.
- rst asserted after 2nd beat of a dcache read -> next cycle state IDLE, pmem_read=0, no d_resp, cnt=0. A subsequent request completes normally.
